// File: rtl/inst_queue.sv
// inst_queue: fetch-to-decode instruction FIFO with a whole-queue flush.
// Define IQ_BYPASS_EN to let a packet pass straight through an empty queue in the same cycle.
module inst_queue #(
    parameter int unsigned DATA_W = 65,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PTR_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_allow,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PTR_W:0]    count
);

    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              empty;
    logic              push_req;
    logic              pop;
    logic              wr_en;
    logic              rd_en;

    // Occupancy alone separates full from empty; pointers wrap naturally.
    assign empty    = (count == '0);
    assign in_allow = (count != FULL_CNT);
    assign push_req = in_valid & in_allow & ~flush;

`ifdef IQ_BYPASS_EN
    logic bypass;

    // An empty queue forwards the incoming packet; it is stored only if decode stalls.
    assign bypass    = empty & in_valid & ~flush;
    assign out_valid = bypass | (~empty & ~flush);
    assign out_data  = bypass ? in_data : mem[head];
    assign pop       = out_valid & out_ready;
    assign wr_en     = push_req & ~(bypass & out_ready);
    assign rd_en     = pop & ~bypass;
`else
    assign out_valid = ~empty & ~flush;
    assign out_data  = mem[head];
    assign pop       = out_valid & out_ready;
    assign wr_en     = push_req;
    assign rd_en     = pop;
`endif

    // Packet storage is left uninitialised; contents are only read while valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[tail] <= in_data;
        end
    end

    // Pointer and occupancy state; flush wins over any push or pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr_en) begin
                tail <= tail + PTR_W'(1);
            end
            if (rd_en) begin
                head <= head + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
Instruction buffer between the fetch stage and the decode stage.
- Accepts fetch packets {pc[31:0], inst[31:0], ex_adef} through a valid/allow handshake.
- Holds up to DEPTH packets in FIFO order.
- Presents the oldest packet to decode.
- Lets fetch keep issuing while decode is stalled. A flush (branch taken or CSR redirect) discards every buffered packet.

Parameters:
- DATA_W, 65, packet width: pc(32) + inst(32) + ex_adef(1), with pc in the MSBs.
- DEPTH, 4, number of entries; must be a power of two, at least 2.
- PTR_W, 2, pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  discard all contents; driven by the branch-taken / CSR-redirect condition.
- in_valid  in  1  fetch presents a packet.
- in_allow  out  1  queue can accept a packet this cycle.
- in_data  in  DATA_W  fetch packet.
- out_valid  out  1  oldest packet available to decode.
- out_ready  in  1  decode accepts the packet.
- out_data  out  DATA_W  oldest packet.
- count  out  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (async, active-high):
  - head, tail and count clear to 0.
  - out_valid=0, in_allow=1, count=0.
  - out_data is don't-care while out_valid=0; the RAM is not cleared.
- Push when in_valid & in_allow & ~flush. The entry is written at tail, then tail increments modulo DEPTH.
- Pop when out_valid & out_ready. Head increments modulo DEPTH.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged; legal at any occupancy that allows both.
- in_allow = (count != DEPTH).
  - It is registered-state only; there is no combinational path from out_ready to in_allow.
  - A full queue therefore refuses input even in a cycle where a pop occurs.
- out_valid = (count != 0) & ~flush. out_data is the entry at head.
- Latency: a pushed packet is visible at out_valid on the next cycle (one-cycle minimum).
- Flush has priority over everything else:
  - In the flush cycle, head, tail and count reset to 0 on the next edge.
  - Any in_valid packet that cycle is dropped.
  - out_valid is forced 0, so no pop occurs.
  - in_allow is unaffected by flush.
  - Flush with an empty queue is harmless.
- Ordering: strict FIFO; packets are never reordered or duplicated.
- Pointer wrap: modulo DEPTH, which is natural overflow of PTR_W bits. Full versus empty is distinguished only by count.
- Packet fields pass through unmodified. ex_adef=1 packets are queued like any other.
- Protocol rules:
  - in_data is sampled only on a push.
  - Once asserted, out_valid/out_data stay stable until a pop or flush.

Optional Feature:
- Macro IQ_BYPASS_EN.
- When defined, empty-queue bypass applies. If count==0, in_valid=1 and ~flush:
  - out_valid=1 and out_data=in_data combinationally.
  - If out_ready=1 that cycle, the packet is consumed without being written; tail and count are unchanged.
  - If out_ready=0, the packet is written normally.
  - Result: zero-cycle latency through an empty queue.
- When not defined, there is no bypass and the one-cycle minimum latency applies. The in-to-out combinational path does not exist.

Test Plan:
1. Reset mid-stream: fill 3 entries, then assert reset asynchronously between edges -> count=0, out_valid=0, in_allow=1 immediately, before the next edge.
2. Fill to full with out_ready=0: push pc=0x1c000000, 0x1c000004, 0x1c000008, 0x1c00000c -> count=4, in_allow=0. A 5th packet with pc=0x1c000010 is held by fetch and not lost. Then out_ready=1 -> pops return 0x1c000000..0x1c00000c in order, followed by 0x1c000010.
3. Simultaneous push/pop at count=2, held for 10 cycles -> count stays 2. Output order matches input across at least two pointer wraps.
4. Flush with count=3 while in_valid=1 (pc=0x1c000020) -> out_valid=0 that cycle and count=0 next cycle. The 0x1c000020 packet never appears. The next push, pc=0x1c000100, is the next packet output.
5. Exception packet: push {pc=0x1c000002, inst=0, ex_adef=1} -> out_data is bit-exact, with ex_adef=1.
6. Empty-queue latency: push pc=0x1c000040 with out_ready=1 into an empty queue.
   - Without IQ_BYPASS_EN: out_valid rises on the next cycle.
   - With IQ_BYPASS_EN: out_valid=1 in the same cycle, the packet is consumed, and count stays 0.
